// File: rtl/requant_unit.sv
// requant_unit
// Per-channel requantization: signed accumulator -> signed OUT_WIDTH activation.
// Each channel has a fixed-point multiplier and a right shift. The shift rounds
// half up. The unit then adds the output zero point, saturates, and applies an
// optional ReLU/ReLU6 clamp.
//
// Pipeline (accept edge N -> valid_out after edge N+3):
//   s1: admission, parameter read, register {data, mult, shift}
//   s2: full-width signed product
//   s3: round-half-up arithmetic right shift (PW+1 bits, cannot overflow)
//   s4: + zero point, saturate, activation clamp -> data_out
//
// Handshake: valid_in/valid_out are single-cycle qualifiers with no backpressure.
// A sample is admitted on an edge where valid_in && enable are high. Parameters
// must be loaded and channel_idx must be in range. Otherwise the sample is
// dropped and drop_err latches.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   enable                          admit new samples into s1
//   load_params, num_channels       restart parameter load / channels in layer
//   param_valid, param_mult/shift   parameter stream, one word per channel
//   act_mode, out_zero_point,
//   relu6_max                       quasi-static output-stage controls
//   valid_in, channel_idx, data_in  accumulator stream
//   valid_out, data_out             requantized stream
//   params_loaded, drop_err         status
module requant_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int MULT_WIDTH   = 32,
   parameter int SHIFT_WIDTH  = 6,
   parameter int OUT_WIDTH    = 8,
   parameter int MAX_CHANNELS = 512
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   load_params,
   input  logic [9:0]             num_channels,
   input  logic                   param_valid,
   input  logic [MULT_WIDTH-1:0]  param_mult,
   input  logic [SHIFT_WIDTH-1:0] param_shift,
   input  logic [1:0]             act_mode,
   input  logic [OUT_WIDTH-1:0]   out_zero_point,
   input  logic [OUT_WIDTH-1:0]   relu6_max,
   input  logic                   valid_in,
   input  logic [9:0]             channel_idx,
   input  logic [DATA_WIDTH-1:0]  data_in,
   output logic                   valid_out,
   output logic [OUT_WIDTH-1:0]   data_out,
   output logic                   params_loaded,
   output logic                   drop_err
);

   localparam int CW = 10;
   localparam int AW = $clog2(MAX_CHANNELS);
   localparam int PW = DATA_WIDTH + MULT_WIDTH;
   localparam int VW = PW + 2;
   localparam logic [CW-1:0] MAX_CH_L = CW'(MAX_CHANNELS);
   localparam logic signed [VW-1:0] V_MAX = {{(VW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [VW-1:0] V_MIN = {{(VW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic signed [OUT_WIDTH-1:0] O_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_WIDTH-1:0] O_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   // Parameter memory (contents intentionally not reset)
   logic [MULT_WIDTH-1:0]  r_mem_mult  [MAX_CHANNELS];
   logic [SHIFT_WIDTH-1:0] r_mem_shift [MAX_CHANNELS];

   logic [CW-1:0] r_wr_idx;
   logic          r_loaded;
   logic          r_drop;

   logic [CW-1:0] w_num_ch;
   logic [CW-1:0] w_last_idx;
   logic          w_wr_en;
   logic          w_accept;

   // A layer size of 0 behaves as a single channel
   assign w_num_ch   = (num_channels == '0) ? CW'(1) : num_channels;
   assign w_last_idx = w_num_ch - CW'(1);
   // load_params takes priority over a same-cycle parameter word
   assign w_wr_en    = param_valid && !r_loaded && !load_params && (r_wr_idx < MAX_CH_L);
   assign w_accept   = valid_in && enable && r_loaded &&
                       (channel_idx < w_num_ch) && (channel_idx < MAX_CH_L);

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem_mult[r_wr_idx[AW-1:0]]  <= param_mult;
         r_mem_shift[r_wr_idx[AW-1:0]] <= param_shift;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_idx <= '0;
         r_loaded <= 1'b0;
         r_drop   <= 1'b0;
      end else if (load_params) begin
         r_wr_idx <= '0;
         r_loaded <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         if (param_valid && !r_loaded) begin
            r_wr_idx <= r_wr_idx + CW'(1);
            if (r_wr_idx == w_last_idx) r_loaded <= 1'b1;
         end
         if (valid_in && enable && !w_accept) r_drop <= 1'b1;
      end
   end

   // ---------------- Pipeline registers ----------------
   logic                          r_s1_valid;
   logic signed [DATA_WIDTH-1:0]  r_s1_data;
   logic signed [MULT_WIDTH-1:0]  r_s1_mult;
   logic [SHIFT_WIDTH-1:0]        r_s1_shift;
   logic                          r_s2_valid;
   logic signed [PW-1:0]          r_s2_prod;
   logic [SHIFT_WIDTH-1:0]        r_s2_shift;
   logic                          r_s3_valid;
   logic signed [PW:0]            r_s3_res;
   logic                          r_valid_out;
   logic [OUT_WIDTH-1:0]          r_data_out;

   logic signed [PW-1:0]          w_prod;
   logic signed [PW:0]            w_prod_x;
   logic signed [PW:0]            w_half;
   logic signed [PW:0]            w_sum;
   logic signed [PW:0]            w_rnd;
   logic signed [VW-1:0]          w_v;
   logic signed [OUT_WIDTH-1:0]   w_sat;
   logic signed [OUT_WIDTH-1:0]   w_zp;
   logic signed [OUT_WIDTH-1:0]   w_r6;
   logic signed [OUT_WIDTH-1:0]   w_act;

   assign w_prod   = PW'(r_s1_data) * PW'(r_s1_mult);
   assign w_prod_x = {r_s2_prod[PW-1], r_s2_prod};
   // Half-LSB rounding constant; unused when the shift is 0
   assign w_half   = (PW+1)'(1) << (r_s2_shift - SHIFT_WIDTH'(1));
   assign w_sum    = w_prod_x + w_half;
   assign w_rnd    = (r_s2_shift == '0) ? w_prod_x : (w_sum >>> r_s2_shift);

   assign w_zp = out_zero_point;
   assign w_r6 = relu6_max;
   assign w_v  = {r_s3_res[PW], r_s3_res} +
                 {{(VW-OUT_WIDTH){out_zero_point[OUT_WIDTH-1]}}, out_zero_point};

   always_comb begin
      w_sat = w_v[OUT_WIDTH-1:0];
      if (w_v > V_MAX)      w_sat = O_MAX;
      else if (w_v < V_MIN) w_sat = O_MIN;
   end

   // Clamps compare against the zero point, the quantized image of 0.0
   always_comb begin
      w_act = w_sat;
      case (act_mode)
         2'd1: if (w_sat < w_zp) w_act = w_zp;
         2'd2: begin
            if (w_sat < w_zp) w_act = w_zp;
            if (w_act > w_r6) w_act = w_r6;
         end
         default: w_act = w_sat;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_mult   <= '0;
         r_s1_shift  <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_prod   <= '0;
         r_s2_shift  <= '0;
         r_s3_valid  <= 1'b0;
         r_s3_res    <= '0;
         r_valid_out <= 1'b0;
         r_data_out  <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_data  <= data_in;
            r_s1_mult  <= r_mem_mult[channel_idx[AW-1:0]];
            r_s1_shift <= r_mem_shift[channel_idx[AW-1:0]];
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_prod  <= w_prod;
            r_s2_shift <= r_s1_shift;
         end
         r_s3_valid <= r_s2_valid;
         if (r_s2_valid) r_s3_res <= w_rnd;
         r_valid_out <= r_s3_valid;
         if (r_s3_valid) r_data_out <= w_act;
      end
   end

   assign valid_out     = r_valid_out;
   assign data_out      = r_data_out;
   assign params_loaded = r_loaded;
   assign drop_err      = r_drop;

endmodule

// File: tb/tb_requant_unit.sv
// Directed bench for requant_unit. The vector table holds hand-computed results.
// Channels 0..2 use mult=2^30 with shift=31, so out = round_half_up(x/2).
// Channel 3 uses mult=1 with shift=0, so out = x.
module tb_requant_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load_params;
   logic [9:0]  num_channels;
   logic        param_valid;
   logic [31:0] param_mult;
   logic [5:0]  param_shift;
   logic [1:0]  act_mode;
   logic [7:0]  out_zero_point;
   logic [7:0]  relu6_max;
   logic        valid_in;
   logic [9:0]  channel_idx;
   logic [31:0] data_in;
   logic        valid_out;
   logic [7:0]  data_out;
   logic        params_loaded;
   logic        drop_err;

   requant_unit dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load_params(load_params),
      .num_channels(num_channels), .param_valid(param_valid),
      .param_mult(param_mult), .param_shift(param_shift), .act_mode(act_mode),
      .out_zero_point(out_zero_point), .relu6_max(relu6_max),
      .valid_in(valid_in), .channel_idx(channel_idx), .data_in(data_in),
      .valid_out(valid_out), .data_out(data_out),
      .params_loaded(params_loaded), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  ch;
      logic [31:0] data;
      logic [1:0]  act;
      logic [7:0]  zp;
      logic [7:0]  r6;
      logic [7:0]  exp;
   } vec_t;

   vec_t       vecs[16];
   logic [7:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic       mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Independent reference for the streamed samples
   function automatic logic [7:0] model(input int ch, input int d, input int act,
                                        input int zp, input int r6);
      longint m, p, r, v;
      int s;
      m = (ch == 3) ? 64'sd1 : 64'sd1073741824;
      s = (ch == 3) ? 0 : 31;
      p = longint'(d) * m;
      if (s == 0) r = p;
      else        r = (p + (64'sd1 <<< (s - 1))) >>> s;
      v = r + longint'(zp);
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      if (act == 1 || act == 2) if (v < zp) v = zp;
      if (act == 2) if (v > r6) v = r6;
      return 8'(v);
   endfunction

   always @(posedge clk) begin
      #1;
      if (mon_en && valid_out) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_unexpected actual=%0h expected=none", data_out);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               errors++;
               $display("FAIL stream_data actual=%0h expected=%0h", data_out, e);
            end
         end
      end
   end

   // The restart cycle carries a garbage word that must be ignored
   task automatic do_load();
      @(negedge clk);
      load_params = 1'b1; param_valid = 1'b1;
      param_mult = 32'h7FFF_FFFF; param_shift = 6'd5;
      @(negedge clk);
      load_params = 1'b0;
      for (int i = 0; i < 4; i++) begin
         param_valid = 1'b1;
         param_mult  = (i == 3) ? 32'd1 : 32'h4000_0000;
         param_shift = (i == 3) ? 6'd0 : 6'd31;
         @(negedge clk);
         if (i == 2) chk("loaded_early", {31'd0, params_loaded}, 32'd0);
         if (i == 3) chk("loaded_after_last", {31'd0, params_loaded}, 32'd1);
      end
      param_valid = 1'b0;
   endtask

   task automatic drop_sample(input logic [9:0] ch, input string name);
      logic seen;
      @(negedge clk);
      valid_in = 1'b1; enable = 1'b1; channel_idx = ch; data_in = 32'd5;
      @(negedge clk);
      valid_in = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (valid_out) seen = 1'b1;
      end
      chk({name, "_no_out"}, {31'd0, seen}, 32'd0);
      chk({name, "_drop_err"}, {31'd0, drop_err}, 32'd1);
   endtask

   task automatic apply_vec(input int idx);
      logic early;
      @(negedge clk);
      act_mode = vecs[idx].act; out_zero_point = vecs[idx].zp; relu6_max = vecs[idx].r6;
      channel_idx = vecs[idx].ch; data_in = vecs[idx].data;
      valid_in = 1'b1; enable = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0;
      early = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (valid_out) early = 1'b1;
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d_early", idx), {31'd0, early}, 32'd0);
      chk($sformatf("vec%0d_valid", idx), {31'd0, valid_out}, 32'd1);
      chk($sformatf("vec%0d_data", idx), {24'd0, data_out}, {24'd0, vecs[idx].exp});
   endtask

   initial begin
      vecs[0]  = '{10'd0, 32'd100,    2'd0, 8'd0,    8'd60,  8'd50};
      vecs[1]  = '{10'd1, 32'd3,      2'd0, 8'd0,    8'd60,  8'd2};
      vecs[2]  = '{10'd2, -32'sd3,    2'd0, 8'd0,    8'd60,  -8'sd1};
      vecs[3]  = '{10'd3, 32'd7,      2'd0, 8'd0,    8'd60,  8'd7};
      vecs[4]  = '{10'd0, 32'd1000,   2'd0, 8'd0,    8'd60,  8'd127};
      vecs[5]  = '{10'd1, -32'sd1000, 2'd0, 8'd0,    8'd60,  -8'sd128};
      vecs[6]  = '{10'd0, 32'd100,    2'd0, -8'sd5,  8'd60,  8'd45};
      vecs[7]  = '{10'd0, -32'sd100,  2'd1, 8'd0,    8'd60,  8'd0};
      vecs[8]  = '{10'd0, 32'd200,    2'd2, 8'd0,    8'd60,  8'd60};
      vecs[9]  = '{10'd3, 32'd50,     2'd2, 8'd0,    8'd60,  8'd50};
      vecs[10] = '{10'd3, -32'sd7,    2'd3, 8'd0,    8'd60,  -8'sd7};
      vecs[11] = '{10'd3, 32'd127,    2'd0, 8'd1,    8'd60,  8'd127};
      vecs[12] = '{10'd3, -32'sd20,   2'd1, 8'd10,   8'd60,  8'd10};
      vecs[13] = '{10'd3, 32'd3,      2'd1, 8'd10,   8'd60,  8'd13};
      vecs[14] = '{10'd2, -32'sd1,    2'd0, 8'd0,    8'd60,  8'd0};
      vecs[15] = '{10'd3, -32'sd128,  2'd0, -8'sd1,  8'd60,  -8'sd128};

      rst_n = 1'b0; enable = 1'b0; load_params = 1'b0; num_channels = 10'd4;
      param_valid = 1'b0; param_mult = '0; param_shift = '0; act_mode = 2'd0;
      out_zero_point = '0; relu6_max = 8'd60; valid_in = 1'b0; channel_idx = '0;
      data_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("rst_data_out", {24'd0, data_out}, 32'd0);
      chk("rst_params_loaded", {31'd0, params_loaded}, 32'd0);
      chk("rst_drop_err", {31'd0, drop_err}, 32'd0);
      rst_n = 1'b1;

      // Drops: not yet loaded, then channel out of range
      drop_sample(10'd0, "unloaded");
      do_load();
      chk("drop_cleared_1", {31'd0, drop_err}, 32'd0);
      drop_sample(10'd4, "ch_range");
      do_load();
      chk("drop_cleared_2", {31'd0, drop_err}, 32'd0);

      for (int i = 0; i < 16; i++) apply_vec(i);

      // Back-to-back stream with enable toggling
      @(negedge clk);
      act_mode = 2'd2; out_zero_point = 8'd3; relu6_max = 8'd100;
      mon_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         int ch, d;
         ch = int'($urandom_range(0, 3));
         d  = int'($urandom_range(0, 4000)) - 2000;
         valid_in = 1'b1; channel_idx = 10'(ch); data_in = 32'(d);
         enable = ($urandom_range(0, 3) != 0);
         if (enable) exp_q.push_back(model(ch, d, 2, 3, 100));
         @(negedge clk);
      end
      valid_in = 1'b0;
      repeat (6) @(negedge clk);
      chk("stream_drained", exp_q.size(), 32'd0);
      chk("stream_no_drop", {31'd0, drop_err}, 32'd0);

      // Asynchronous reset with three samples in flight
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1; enable = 1'b1; channel_idx = 10'(i); data_in = 32'd40;
         @(negedge clk);
      end
      valid_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("mid_rst_data_out", {24'd0, data_out}, 32'd0);
      chk("mid_rst_params_loaded", {31'd0, params_loaded}, 32'd0);
      begin
         logic seen;
         seen = 1'b0;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         repeat (6) begin
            @(negedge clk);
            if (valid_out || data_out != 8'd0) seen = 1'b1;
         end
         chk("mid_rst_no_out", {31'd0, seen}, 32'd0);
      end
      mon_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/requant_unit.md
# requant_unit

Per-channel requantization stage: converts the signed 32-bit bias-added accumulator stream into signed 8-bit activations using a per-channel fixed-point multiplier and right shift, with round-half-up, output zero point, optional ReLU/ReLU6 clamp and saturation. It sits directly downstream of the bias addition stage, consuming its `valid_out`/`data_out` plus the forwarded channel index, and feeds the activation writeback buffer. Per-channel parameters are streamed in once per layer through a load interface.

## Interface
Parameters:
- DATA_WIDTH, 32, input accumulator width (signed)
- MULT_WIDTH, 32, per-channel multiplier width (signed, Q0.31 convention)
- SHIFT_WIDTH, 6, per-channel right-shift width (0..63)
- OUT_WIDTH, 8, output width (signed)
- MAX_CHANNELS, 512, parameter memory depth

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  admit new samples into stage 1
- load_params  in  1  restart parameter load (pulse)
- num_channels  in  10  channels in layer, 1..512 (0 treated as 1)
- param_valid  in  1  parameter word valid
- param_mult  in  MULT_WIDTH  signed multiplier for next channel
- param_shift  in  SHIFT_WIDTH  right shift for next channel
- act_mode  in  2  0 none, 1 ReLU, 2 ReLU6, 3 reserved (= none)
- out_zero_point  in  OUT_WIDTH  signed output zero point
- relu6_max  in  OUT_WIDTH  signed quantized upper bound for ReLU6
- valid_in  in  1  input sample valid
- channel_idx  in  10  channel of data_in
- data_in  in  DATA_WIDTH  signed accumulator
- valid_out  out  1  output valid
- data_out  out  OUT_WIDTH  signed requantized value
- params_loaded  out  1  all num_channels entries written
- drop_err  out  1  sticky: a valid_in sample was discarded

## Operation
- Parameter load: index counter resets to 0 and params_loaded clears on load_params. Each param_valid while !params_loaded writes {mult, shift} at index, then increments; write at index num_channels-1 sets params_loaded. param_valid while params_loaded: ignored. load_params and param_valid same cycle: load_params wins, word ignored.
- Sample admission (stage 1): valid_in && enable && params_loaded && channel_idx < num_channels → accepted; parameters read and registered with data. valid_in && enable otherwise → discarded, drop_err set. enable low → no admission, no error; in-flight samples keep draining.
- drop_err cleared only by load_params or reset.
- Stage 2: prod = data_in * mult, full 64-bit signed product.
- Stage 3: shift s = 0 → r = prod; s > 0 → r = (prod + 2^(s-1)) >>> s, computed in 65 bits (no overflow). v = r + out_zero_point. Saturate to [-128, 127] (OUT_WIDTH generic). Then ReLU: v = max(v, out_zero_point); ReLU6: v = min(max(v, out_zero_point), relu6_max). Result registered to data_out.
- act_mode, out_zero_point, relu6_max are sampled in stage 3 (quasi-static per layer; change only when pipeline is empty).
- Parameter memory contents are not reset.

## Timing
- Latency: sample accepted at edge N → valid_out high for one cycle after edge N+3; throughput 1 sample/cycle, no backpressure.
- Reset values: valid_out 0, data_out 0, params_loaded 0, drop_err 0; all pipeline valids 0.
- params_loaded rises the cycle after the final param_valid write; a sample may be admitted that same cycle.
- Parameter write to index k at edge N is visible to samples admitted at edge N+1 or later.
- load_params during streaming: params_loaded drops next cycle, new admissions rejected; samples already past stage 1 complete with their registered parameters.
- Reset mid-operation: pipeline flushed immediately, no valid_out produced for in-flight samples.

## Test plan
- Load 4 channels, each mult=2^30, shift=31, zp=0, act none; data_in=100 ch0 → data_out=50 exactly 3 cycles later; params_loaded high after 4th word.
- Rounding: data_in=3 → 2; data_in=-3 → -1 (half up); shift=0, mult=1, data_in=7 → 7.
- Saturation: data_in=1000 → 127; data_in=-1000 → -128; zp=-5 with data_in=100 → 45.
- Activation: ReLU, zp=0, data_in=-100 → 0; ReLU6, relu6_max=60, data_in=200 → 60.
- Errors: valid_in before params_loaded, and channel_idx=4 with num_channels=4 → no valid_out, drop_err=1; load_params clears drop_err.
- Back-to-back 64 samples across channels with enable toggled and async reset asserted mid-stream → outputs match model, none after reset, all outputs 0.
